// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator with registered output stage.
//
// Optional feature macro: VGA_TESTPAT_EN (adds an 8-bar colour test pattern
// selected by test_mode; when undefined, test_mode is ignored).
//
// Ports:
//   clk          system clock (only clock)
//   rst_n        asynchronous active-low reset
//   rgb_in       12-bit {r,g,b} colour for the current x_loc/y_loc
//   test_mode    selects the colour-bar source (VGA_TESTPAT_EN builds only)
//   pix_en       one-clk pulse per pixel tick (constant high when CLK_DIV=1)
//   x_loc/y_loc  current pixel address (counters truncated to 10 bits)
//   line_start   high for the tick at which h_cnt=0
//   frame_start  high for the tick at which h_cnt=0 and v_cnt=0
//   h_sync/v_sync/video_on, red/green/blue
//                timing and colour, registered one tick after x_loc/y_loc
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] rgb_in,
   input  logic        test_mode,
   output logic        pix_en,
   output logic [9:0]  x_loc,
   output logic [9:0]  y_loc,
   output logic        line_start,
   output logic        frame_start,
   output logic        h_sync,
   output logic        v_sync,
   output logic        video_on,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic HS_ON = 1'(HS_POL);
   localparam logic VS_ON = 1'(VS_POL);

   // ST_PRIME: first tick after reset shows pixel (0,0) with frame_start
   // without advancing the counters or loading the output stage.
   typedef enum logic {ST_PRIME, ST_RUN} state_t;
   state_t state;

   logic [3:0]  div_cnt;
   logic        tick;
   logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic        raw_active, raw_hs, raw_vs;
   logic [11:0] src;

   assign tick  = (div_cnt == 4'(CLK_DIV - 1));
   assign x_loc = h_cnt[9:0];
   assign y_loc = v_cnt[9:0];

   always_comb begin
      h_nxt = h_cnt + 16'd1;
      v_nxt = v_cnt;
      if (h_cnt == 16'(H_TOTAL - 1)) begin
         h_nxt = '0;
         v_nxt = (v_cnt == 16'(V_TOTAL - 1)) ? '0 : v_cnt + 16'd1;
      end
   end

   assign raw_active = (h_cnt < 16'(H_ACTIVE)) && (v_cnt < 16'(V_ACTIVE));
   assign raw_hs     = (h_cnt >= 16'(H_ACTIVE + H_FP)) &&
                       (h_cnt <  16'(H_ACTIVE + H_FP + H_SYNC));
   assign raw_vs     = (v_cnt >= 16'(V_ACTIVE + V_FP)) &&
                       (v_cnt <  16'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VGA_TESTPAT_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   logic [2:0]  bar;
   logic [11:0] bar_rgb;

   // Bar colours white..black map to r=~bar[1], g=~bar[2], b=~bar[0].
   always_comb begin
      if (h_cnt >= 16'(7 * BAR_W))
         bar = 3'd7;
      else
         bar = 3'(h_cnt / 16'(BAR_W));
      bar_rgb = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
      src     = test_mode ? bar_rgb : rgb_in;
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign src = rgb_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PRIME;
         div_cnt     <= '0;
         pix_en      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         video_on    <= 1'b0;
         h_sync      <= ~HS_ON;
         v_sync      <= ~VS_ON;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         pix_en  <= tick;
         div_cnt <= tick ? '0 : div_cnt + 4'd1;
         if (tick) begin
            case (state)
               ST_PRIME: begin
                  state       <= ST_RUN;
                  line_start  <= 1'b1;
                  frame_start <= 1'b1;
               end
               ST_RUN: begin
                  h_cnt       <= h_nxt;
                  v_cnt       <= v_nxt;
                  line_start  <= (h_nxt == '0);
                  frame_start <= (h_nxt == '0) && (v_nxt == '0);
                  // Output stage samples the pixel that was addressed
                  // during the tick just ending.
                  video_on    <= raw_active;
                  h_sync      <= raw_hs ? HS_ON : ~HS_ON;
                  v_sync      <= raw_vs ? VS_ON : ~VS_ON;
                  red         <= raw_active ? src[11:8] : '0;
                  green       <= raw_active ? src[7:4]  : '0;
                  blue        <= raw_active ? src[3:0]  : '0;
               end
               default: state <= ST_PRIME;
            endcase
         end
      end
   end

endmodule
